// File: rtl/move_sequencer.sv
// move_sequencer: decodes 16-bit move commands and sequences rotate, ramp-up, line counting and ramp-down for the heading PID.
// Define IR_NUDGE_EN to bias the heading error from the side-rail IR sensors while driving forward.
module move_sequencer #(
  parameter logic [9:0]  MAX_SPD    = 10'h2A0,
  parameter logic [9:0]  FRWRD_INC  = 10'h018,
  parameter logic [9:0]  FRWRD_DEC  = 10'h030,
  parameter logic [11:0] ERR_THRESH = 12'h030,
  parameter logic [11:0] NUDGE      = 12'h05F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  input  logic        lftIR,
  input  logic        rghtIR,
  output logic        moving,
  output logic [9:0]  frwrd,
  output logic [11:0] error,
  output logic        err_vld,
  output logic        send_resp
);

  typedef enum logic [2:0] {IDLE, ROTATE, RAMP_UP, RAMP_DOWN, DONE} state_t;

  localparam logic [3:0] OP_MOVE = 4'h2;

  state_t      state_q, state_d;
  logic        moving_q, moving_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic [11:0] desired_hdg_q, desired_hdg_d;
  logic [3:0]  sq_q, sq_d;
  logic [4:0]  line_cnt_q, line_cnt_d;
  logic        cntr_ir_q, cntr_ir_d;

  logic [11:0] err_raw;
  logic [11:0] err_abs;
  logic        cntr_rise;
  logic [10:0] frwrd_up;
  logic        clr_cmd_rdy_c;
  logic        send_resp_c;

  assign err_raw   = heading - desired_hdg_q;
  // 12'h800 negates to itself and so stays above any sane threshold
  assign err_abs   = err_raw[11] ? (~err_raw + 12'd1) : err_raw;
  assign cntr_rise = cntrIR & ~cntr_ir_q;
  assign frwrd_up  = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};

`ifdef IR_NUDGE_EN
  always_comb begin
    error = err_raw;
    if (state_q == RAMP_UP || state_q == RAMP_DOWN) begin
      if (lftIR && !rghtIR)      error = err_raw - NUDGE;
      else if (rghtIR && !lftIR) error = err_raw + NUDGE;
    end
  end
`else
  logic unused_ir;
  assign unused_ir = lftIR ^ rghtIR ^ (^NUDGE);
  assign error     = err_raw;
`endif

  assign err_vld     = heading_rdy & moving_q;
  assign moving      = moving_q;
  assign frwrd       = frwrd_q;
  assign clr_cmd_rdy = clr_cmd_rdy_c & ~rst;
  assign send_resp   = send_resp_c & ~rst;

  always_comb begin
    state_d       = state_q;
    frwrd_d       = frwrd_q;
    desired_hdg_d = desired_hdg_q;
    sq_d          = sq_q;
    line_cnt_d    = line_cnt_q;
    cntr_ir_d     = cntrIR;
    clr_cmd_rdy_c = 1'b0;
    send_resp_c   = 1'b0;

    case (state_q)
      IDLE: begin
        frwrd_d = '0;
        if (cmd_rdy) begin
          clr_cmd_rdy_c = 1'b1;
          desired_hdg_d = {cmd[11:4], 4'h0};
          sq_d          = cmd[3:0];
          line_cnt_d    = '0;
          state_d       = (cmd[15:12] == OP_MOVE) ? ROTATE : DONE;
        end
      end
      ROTATE: begin
        frwrd_d = '0;
        if (heading_rdy && (err_abs < ERR_THRESH))
          state_d = (sq_q == 4'h0) ? RAMP_DOWN : RAMP_UP;
      end
      RAMP_UP: begin
        if (heading_rdy)
          frwrd_d = (frwrd_up > {1'b0, MAX_SPD}) ? MAX_SPD : frwrd_up[9:0];
        if (cntr_rise)
          line_cnt_d = line_cnt_q + 5'd1;
        // compared against the registered count so a coincident edge is still counted
        if (line_cnt_q == {sq_q, 1'b0})
          state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (heading_rdy)
          frwrd_d = (frwrd_q < FRWRD_DEC) ? '0 : (frwrd_q - FRWRD_DEC);
        if (frwrd_q == '0)
          state_d = DONE;
      end
      DONE: begin
        frwrd_d     = '0;
        send_resp_c = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    moving_d = (state_d == ROTATE) || (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      moving_q      <= 1'b0;
      frwrd_q       <= '0;
      desired_hdg_q <= '0;
      sq_q          <= '0;
      line_cnt_q    <= '0;
      cntr_ir_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      moving_q      <= moving_d;
      frwrd_q       <= frwrd_d;
      desired_hdg_q <= desired_hdg_d;
      sq_q          <= sq_d;
      line_cnt_q    <= line_cnt_d;
      cntr_ir_q     <= cntr_ir_d;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed self-checking bench for move_sequencer; inputs change and outputs are checked just after the falling edge.
module tb_move_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [11:0] heading;
  logic        heading_rdy;
  logic        cntrIR;
  logic        lftIR;
  logic        rghtIR;
  logic        moving;
  logic [9:0]  frwrd;
  logic [11:0] error;
  logic        err_vld;
  logic        send_resp;

  int total = 0;
  int bad   = 0;

  move_sequencer dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .heading(heading), .heading_rdy(heading_rdy), .cntrIR(cntrIR),
    .lftIR(lftIR), .rghtIR(rghtIR), .moving(moving), .frwrd(frwrd),
    .error(error), .err_vld(err_vld), .send_resp(send_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd = '0; cmd_rdy = 1'b0; heading = '0; heading_rdy = 1'b0;
    cntrIR = 1'b0; lftIR = 1'b0; rghtIR = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (moving !== 1'b0) begin bad++; $display("FAIL reset_moving got=%b exp=0", moving); end
    total++; if (frwrd !== 10'h000) begin bad++; $display("FAIL reset_frwrd got=%h exp=000", frwrd); end
    total++; if (clr_cmd_rdy !== 1'b0 || send_resp !== 1'b0) begin bad++;
      $display("FAIL reset_pulses got clr=%b resp=%b exp 0 0", clr_cmd_rdy, send_resp); end
    total++; if (error !== 12'h000) begin bad++; $display("FAIL reset_error got=%h exp=000", error); end
  endtask

  task automatic test_move_full();
    logic [9:0] exp_f;
    step();
    heading = 12'h000; cmd = 16'h2001; cmd_rdy = 1'b1;
    #1;
    total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL move_clr got=%b exp=1", clr_cmd_rdy); end
    step();
    cmd_rdy = 1'b0;
    #1;
    total++; if (clr_cmd_rdy !== 1'b0 || moving !== 1'b1 || frwrd !== 10'h000) begin bad++;
      $display("FAIL move_rotate got clr=%b mov=%b frwrd=%h exp 0 1 000", clr_cmd_rdy, moving, frwrd); end
    heading_rdy = 1'b1;
    #1;
    total++; if (err_vld !== 1'b1 || error !== 12'h000) begin bad++;
      $display("FAIL move_errvld got vld=%b err=%h exp 1 000", err_vld, error); end
    step();
    #1;
    total++; if (frwrd !== 10'h000 || moving !== 1'b1) begin bad++;
      $display("FAIL move_enter_up got frwrd=%h mov=%b exp 000 1", frwrd, moving); end
    exp_f = 10'h000;
    for (int i = 0; i < 30; i++) begin
      step();
      #1;
      exp_f = (exp_f + 10'h018 > 10'h2A0) ? 10'h2A0 : exp_f + 10'h018;
      total++; if (frwrd !== exp_f) begin bad++; $display("FAIL ramp_up_%0d got=%h exp=%h", i, frwrd, exp_f); end
    end
    heading_rdy = 1'b0;
    cntrIR = 1'b1;
    step(); step(); step();
    heading_rdy = 1'b1;
    step();
    heading_rdy = 1'b0;
    #1;
    total++; if (frwrd !== 10'h2A0) begin bad++; $display("FAIL one_edge_still_up got=%h exp=2a0", frwrd); end
    cntrIR = 1'b0;
    step();
    cntrIR = 1'b1;
    step();
    cntrIR = 1'b0;
    step();
    #1;
    total++; if (frwrd !== 10'h2A0 || moving !== 1'b1) begin bad++;
      $display("FAIL enter_down got frwrd=%h mov=%b exp 2a0 1", frwrd, moving); end
    heading_rdy = 1'b1;
    exp_f = 10'h2A0;
    for (int i = 0; i < 14; i++) begin
      step();
      #1;
      exp_f = exp_f - 10'h030;
      total++; if (frwrd !== exp_f) begin bad++; $display("FAIL ramp_down_%0d got=%h exp=%h", i, frwrd, exp_f); end
    end
    heading_rdy = 1'b0;
    #1;
    total++; if (send_resp !== 1'b0) begin bad++; $display("FAIL resp_early got=%b exp=0", send_resp); end
    step();
    #1;
    total++; if (send_resp !== 1'b1 || moving !== 1'b0) begin bad++;
      $display("FAIL move_done got resp=%b mov=%b exp 1 0", send_resp, moving); end
    step();
    #1;
    total++; if (send_resp !== 1'b0) begin bad++; $display("FAIL resp_once got=%b exp=0", send_resp); end
  endtask

  task automatic test_rotate_thresh();
    logic [11:0] hv [4] = '{12'h000, 12'hFF0, 12'h7C0, 12'h820};
    logic [11:0] ev [4] = '{12'h810, 12'h800, 12'hFD0, 12'h030};
    step();
    heading = 12'h000; cmd = 16'h27F0; cmd_rdy = 1'b1;
    #1;
    total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL rot_clr got=%b exp=1", clr_cmd_rdy); end
    step();
    cmd_rdy = 1'b0;
    #1;
    total++; if (error !== 12'h810 || moving !== 1'b1 || frwrd !== 10'h000) begin bad++;
      $display("FAIL rot_start got err=%h mov=%b frwrd=%h exp 810 1 000", error, moving, frwrd); end
    for (int i = 0; i < 4; i++) begin
      heading = hv[i]; heading_rdy = 1'b1;
      #1;
      total++; if (error !== ev[i]) begin bad++; $display("FAIL rot_err_%0d got=%h exp=%h", i, error, ev[i]); end
      step();
      heading_rdy = 1'b0;
      step();
      #1;
      total++; if (send_resp !== 1'b0 || moving !== 1'b1) begin bad++;
        $display("FAIL rot_hold_%0d got resp=%b mov=%b exp 0 1", i, send_resp, moving); end
    end
    heading = 12'h7E0; heading_rdy = 1'b1;
    #1;
    total++; if (error !== 12'hFF0 || err_vld !== 1'b1) begin bad++;
      $display("FAIL rot_exit_err got err=%h vld=%b exp ff0 1", error, err_vld); end
    step();
    heading_rdy = 1'b0;
    #1;
    total++; if (frwrd !== 10'h000 || moving !== 1'b1 || send_resp !== 1'b0) begin bad++;
      $display("FAIL rot_down got frwrd=%h mov=%b resp=%b exp 000 1 0", frwrd, moving, send_resp); end
    step();
    #1;
    total++; if (send_resp !== 1'b1 || moving !== 1'b0 || frwrd !== 10'h000) begin bad++;
      $display("FAIL rot_done got resp=%b mov=%b frwrd=%h exp 1 0 000", send_resp, moving, frwrd); end
    step();
    #1;
    total++; if (send_resp !== 1'b0) begin bad++; $display("FAIL rot_resp_once got=%b exp=0", send_resp); end
  endtask

  task automatic test_non_move();
    step();
    cmd = 16'h5000; cmd_rdy = 1'b1;
    #1;
    total++; if (clr_cmd_rdy !== 1'b1 || send_resp !== 1'b0) begin bad++;
      $display("FAIL nm_accept got clr=%b resp=%b exp 1 0", clr_cmd_rdy, send_resp); end
    step();
    cmd_rdy = 1'b0;
    #1;
    total++; if (send_resp !== 1'b1 || moving !== 1'b0 || clr_cmd_rdy !== 1'b0) begin bad++;
      $display("FAIL nm_done got resp=%b mov=%b clr=%b exp 1 0 0", send_resp, moving, clr_cmd_rdy); end
    step();
    #1;
    total++; if (send_resp !== 1'b0 || moving !== 1'b0 || frwrd !== 10'h000) begin bad++;
      $display("FAIL nm_idle got resp=%b mov=%b frwrd=%h exp 0 0 000", send_resp, moving, frwrd); end
  endtask

  task automatic test_back_to_back();
    step();
    heading = 12'h000; cmd = 16'h2000; cmd_rdy = 1'b1;
    #1;
    total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL b2b_clr1 got=%b exp=1", clr_cmd_rdy); end
    step();
    cmd = 16'h5000;
    #1;
    total++; if (clr_cmd_rdy !== 1'b0) begin bad++; $display("FAIL b2b_rot_clr got=%b exp=0", clr_cmd_rdy); end
    heading_rdy = 1'b1;
    step();
    heading_rdy = 1'b0;
    #1;
    total++; if (clr_cmd_rdy !== 1'b0 || moving !== 1'b1) begin bad++;
      $display("FAIL b2b_down got clr=%b mov=%b exp 0 1", clr_cmd_rdy, moving); end
    step();
    #1;
    total++; if (send_resp !== 1'b1 || clr_cmd_rdy !== 1'b0) begin bad++;
      $display("FAIL b2b_done got resp=%b clr=%b exp 1 0", send_resp, clr_cmd_rdy); end
    step();
    #1;
    total++; if (clr_cmd_rdy !== 1'b1 || send_resp !== 1'b0) begin bad++;
      $display("FAIL b2b_clr2 got clr=%b resp=%b exp 1 0", clr_cmd_rdy, send_resp); end
    step();
    cmd_rdy = 1'b0;
    #1;
    total++; if (send_resp !== 1'b1) begin bad++; $display("FAIL b2b_resp2 got=%b exp=1", send_resp); end
    step();
  endtask

  task automatic test_reset_mid_move();
    step();
    heading = 12'hAB0; cmd = 16'h2AB1; cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0; heading_rdy = 1'b1;
    step(); step(); step(); step();
    heading_rdy = 1'b0;
    #1;
    total++; if (frwrd !== 10'h048 || moving !== 1'b1) begin bad++;
      $display("FAIL mid_pre got frwrd=%h mov=%b exp 048 1", frwrd, moving); end
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (moving !== 1'b0 || frwrd !== 10'h000 || send_resp !== 1'b0) begin bad++;
      $display("FAIL mid_reset got mov=%b frwrd=%h resp=%b exp 0 000 0", moving, frwrd, send_resp); end
    total++; if (error !== 12'hAB0) begin bad++; $display("FAIL mid_hdg_clear got=%h exp=ab0", error); end
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      total++; if (send_resp !== 1'b0 || moving !== 1'b0 || err_vld !== 1'b0) begin bad++;
        $display("FAIL mid_idle_%0d got resp=%b mov=%b vld=%b exp 0 0 0", i, send_resp, moving, err_vld); end
      heading_rdy = ~heading_rdy;
    end
    heading_rdy = 1'b0;
  endtask

  task automatic test_nudge();
    step();
    heading = 12'h000; cmd = 16'h2001; cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0; lftIR = 1'b1;
    #1;
    total++; if (error !== 12'h000) begin bad++; $display("FAIL nudge_rotate got=%h exp=000", error); end
    heading_rdy = 1'b1;
    step();
    heading_rdy = 1'b0;
    #1;
`ifdef IR_NUDGE_EN
    total++; if (error !== 12'hFA1) begin bad++; $display("FAIL nudge_left got=%h exp=fa1", error); end
    rghtIR = 1'b1;
    #1;
    total++; if (error !== 12'h000) begin bad++; $display("FAIL nudge_both got=%h exp=000", error); end
    lftIR = 1'b0;
    #1;
    total++; if (error !== 12'h05F) begin bad++; $display("FAIL nudge_right got=%h exp=05f", error); end
`else
    total++; if (error !== 12'h000) begin bad++; $display("FAIL nudge_off_left got=%h exp=000", error); end
    rghtIR = 1'b1; lftIR = 1'b0;
    #1;
    total++; if (error !== 12'h000) begin bad++; $display("FAIL nudge_off_right got=%h exp=000", error); end
`endif
    lftIR = 1'b0; rghtIR = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++; if (moving !== 1'b0) begin bad++; $display("FAIL nudge_abort got=%b exp=0", moving); end
  endtask

  initial begin
    test_reset();
    test_move_full();
    test_rotate_thresh();
    test_non_move();
    test_back_to_back();
    test_reset_mid_move();
    test_nudge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
